hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline control for the IF/ID→EX/MEM boundary.
- Watches operands decoded in IF/ID and destinations held in EX/MEM and WB.
- Drives the ENABLE of the PC and of the IF/ID→EX/MEM pipeline register, a BUBBLE request that loads that register with a NOP, and operand-forwarding selects.
- Sequences load-use stalls, data-memory wait states and branch flushes via a small FSM.

Parameters:
- REG_AW, 4, register-address width (16-entry bank)
- STALL_CW, 8, width of saturating stall-cycle counter

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- id_RA  in  4  source A address of instruction in IF/ID
- id_RB  in  4  source B address of instruction in IF/ID
- id_USE_RA  in  1  instruction reads RA
- id_USE_RB  in  1  instruction reads RB
- ex_WC  in  4  destination held in EX/MEM register
- ex_W_RB  in  1  EX/MEM instruction writes register bank
- ex_S_MXRB  in  2  EX/MEM write-back source select
- ex_W_DM  in  1  EX/MEM instruction writes data memory
- ex_BR_TAKEN  in  1  FU resolved a taken branch/jump this cycle
- dm_READY  in  1  data memory completes access this cycle
- wb_WC  in  4  destination in write-back stage
- wb_W_RB  in  1  write-back stage writes register bank
- PC_ENABLE  out  1  PC update enable
- IFID_ENABLE  out  1  ENABLE of the IF/ID→EX/MEM register
- BUBBLE  out  1  load NOP into EX/MEM: W_RF=0, W_DM=0, W_RB=0, OP_ALU=passb
- FLUSH  out  1  squash instruction currently in IF/ID
- FWD_A  out  2  operand-A source: 00 bank, 01 EX result, 10 WB data
- FWD_B  out  2  as FWD_A for operand B
- STALL_CNT  out  STALL_CW  saturating count of stalled cycles

Behaviour:
- States: RUN, LOAD_STALL, MEM_WAIT, FLUSH.
- Definitions:
  - ex_is_load = ex_W_RB & (ex_S_MXRB == MXRB_DM).
  - ex_mem = ex_is_load | ex_W_DM.
  - raw_X(ra) = id_USE_RA & (id_RA == X_WC) & X_W_RB; same form for RB.
- Reset (RESET=1 at posedge):
  - state→RUN, STALL_CNT→0.
  - While RESET is high: PC_ENABLE=0, IFID_ENABLE=0, BUBBLE=1, FLUSH=0, FWD_A=FWD_B=00.
- RUN, priority high→low:
  1. ex_mem & !dm_READY → MEM_WAIT. This cycle: PC_ENABLE=0, IFID_ENABLE=0, BUBBLE=0.
  2. ex_BR_TAKEN → FLUSH. This cycle: PC_ENABLE=1 (loads target), IFID_ENABLE=1, BUBBLE=1, FLUSH=1.
  3. Load-use: ex_is_load & (raw_ex(RA) | raw_ex(RB)) → LOAD_STALL. This cycle: PC_ENABLE=0, IFID_ENABLE=1, BUBBLE=1.
  4. Otherwise: stay in RUN, PC_ENABLE=1, IFID_ENABLE=1, BUBBLE=0.
- LOAD_STALL: exactly one cycle, then RUN. Enables=1, BUBBLE=0. Load data is now in WB and forwarded via 10.
- MEM_WAIT: PC_ENABLE=0, IFID_ENABLE=0. Leave to RUN in the cycle dm_READY=1; that cycle enables=1. ex_BR_TAKEN is ignored while waiting.
- FLUSH: one cycle, FLUSH=1, BUBBLE=1, then RUN. A second taken branch is impossible here because the flushed slot is a NOP.
- Stall counting: STALL_CNT increments in every cycle with PC_ENABLE=0 (RESET low) and saturates at all-ones.
- Forwarding (combinational from inputs, all states):
  - FWD_A=01 if raw_ex(RA) & !ex_is_load.
  - Else FWD_A=10 if raw_wb(RA).
  - Else 00. EX takes priority over WB. FWD_B identical on RB.
- Latency: hazard detection and outputs are same-cycle combinational from state and inputs; only state and STALL_CNT are registered.

Optional Feature:
- FORWARDING_EN
- Defined: forwarding as above.
- Undefined:
  - FWD_A/FWD_B tied 00.
  - Any raw_ex or raw_wb on a used operand, load or not, stalls: PC_ENABLE=0, IFID_ENABLE=1, BUBBLE=1, state stays RUN.
  - Stall repeats each cycle until the hazard clears.
  - Priorities 1 and 2 unchanged.

Decomposition:
- Package hazard_pkg:
  - state enum {RUN, LOAD_STALL, MEM_WAIT, FLUSH}.
  - FWD_BANK=2'b00, FWD_EX=2'b01, FWD_WB=2'b10.
  - MXRB_DM=2'b01.
  - OP_ALU_PASSB=5'b10011.
- One natural sub-module: fwd_sel (comparator/priority for one operand), instantiated twice.

Test Plan:
- Load r3 in EX (ex_W_RB=1, ex_S_MXRB=01, ex_WC=3, dm_READY=1), id_RA=3 used → PC_ENABLE=0, BUBBLE=1 one cycle; next cycle state RUN, FWD_A=10 with wb_WC=3.
- ALU write r5 in EX and WB both (ex_WC=wb_WC=5), id_RB=5 → FWD_B=01. Remove EX write → FWD_B=10. Clear id_USE_RB → 00.
- Store (ex_W_DM=1), dm_READY low 3 cycles → PC_ENABLE=IFID_ENABLE=0 for 3 cycles, released on 4th; STALL_CNT=3.
- ex_BR_TAKEN=1 together with a load-use match → FLUSH=1, BUBBLE=1, PC_ENABLE=1; no LOAD_STALL entered.
- RESET asserted in 2nd MEM_WAIT cycle → next cycle state RUN, STALL_CNT=0; while RESET high BUBBLE=1, enables 0.
- Hold dm_READY=0 for 300 cycles → STALL_CNT saturates at 255. Without FORWARDING_EN, ALU RAW on r5 gives BUBBLE=1 each cycle until ex_W_RB and wb_W_RB clear.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and encodings for the hazard_ctrl pipeline control.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    localparam logic [1:0] FWD_BANK     = 2'b00;
    localparam logic [1:0] FWD_EX       = 2'b01;
    localparam logic [1:0] FWD_WB       = 2'b10;

    localparam logic [1:0] MXRB_DM      = 2'b01;

    // ALU opcode the bubbled EX/MEM slot carries
    localparam logic [4:0] OP_ALU_PASSB = 5'b10011;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel
// Purpose  : RAW comparators and EX-over-WB forwarding priority for one
//            source operand.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic              i_use,
    input  logic [REG_AW-1:0] i_ra,
    input  logic [REG_AW-1:0] i_ex_wc,
    input  logic              i_ex_w_rb,
    input  logic              i_ex_is_load,
    input  logic [REG_AW-1:0] i_wb_wc,
    input  logic              i_wb_w_rb,
    output logic              o_raw_ex,
    output logic              o_raw_wb,
    output logic [1:0]        o_fwd
);

    assign o_raw_ex = i_use & (i_ra == i_ex_wc) & i_ex_w_rb;
    assign o_raw_wb = i_use & (i_ra == i_wb_wc) & i_wb_w_rb;

    // A load in EX has no result yet, so only WB can supply the operand
    always_comb begin
        o_fwd = FWD_BANK;
        if (o_raw_ex && !i_ex_is_load) begin
            o_fwd = FWD_EX;
        end else if (o_raw_wb) begin
            o_fwd = FWD_WB;
        end
    end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Stall/flush/forwarding control for the IF/ID -> EX/MEM boundary.
//            FORWARDING_EN selects operand forwarding; without it every RAW
//            hazard stalls until the writer retires.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int STALL_CW = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [REG_AW-1:0]   id_RA,
    input  logic [REG_AW-1:0]   id_RB,
    input  logic                id_USE_RA,
    input  logic                id_USE_RB,
    input  logic [REG_AW-1:0]   ex_WC,
    input  logic                ex_W_RB,
    input  logic [1:0]          ex_S_MXRB,
    input  logic                ex_W_DM,
    input  logic                ex_BR_TAKEN,
    input  logic                dm_READY,
    input  logic [REG_AW-1:0]   wb_WC,
    input  logic                wb_W_RB,
    output logic                PC_ENABLE,
    output logic                IFID_ENABLE,
    output logic                BUBBLE,
    output logic                FLUSH,
    output logic [1:0]          FWD_A,
    output logic [1:0]          FWD_B,
    output logic [STALL_CW-1:0] STALL_CNT
);

    state_t              r_state;
    state_t              w_next;
    logic [STALL_CW-1:0] r_stall_cnt;

    logic w_ex_is_load;
    logic w_ex_mem;
    logic w_raw_ex_a, w_raw_ex_b;
    logic w_raw_wb_a, w_raw_wb_b;
    logic [1:0] w_fwd_a, w_fwd_b;
    logic w_pc_en, w_ifid_en, w_bubble, w_flush;

    assign w_ex_is_load = ex_W_RB & (ex_S_MXRB == MXRB_DM);
    assign w_ex_mem     = w_ex_is_load | ex_W_DM;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .i_use        (id_USE_RA),
        .i_ra         (id_RA),
        .i_ex_wc      (ex_WC),
        .i_ex_w_rb    (ex_W_RB),
        .i_ex_is_load (w_ex_is_load),
        .i_wb_wc      (wb_WC),
        .i_wb_w_rb    (wb_W_RB),
        .o_raw_ex     (w_raw_ex_a),
        .o_raw_wb     (w_raw_wb_a),
        .o_fwd        (w_fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .i_use        (id_USE_RB),
        .i_ra         (id_RB),
        .i_ex_wc      (ex_WC),
        .i_ex_w_rb    (ex_W_RB),
        .i_ex_is_load (w_ex_is_load),
        .i_wb_wc      (wb_WC),
        .i_wb_w_rb    (wb_W_RB),
        .o_raw_ex     (w_raw_ex_b),
        .o_raw_wb     (w_raw_wb_b),
        .o_fwd        (w_fwd_b)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= hazard_pkg::RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pc_en   = 1'b1;
        w_ifid_en = 1'b1;
        w_bubble  = 1'b0;
        w_flush   = 1'b0;
        case (r_state)
            hazard_pkg::RUN: begin
                if (w_ex_mem && !dm_READY) begin
                    w_next    = hazard_pkg::MEM_WAIT;
                    w_pc_en   = 1'b0;
                    w_ifid_en = 1'b0;
                end else if (ex_BR_TAKEN) begin
                    w_next   = hazard_pkg::FLUSH;
                    w_bubble = 1'b1;
                    w_flush  = 1'b1;
`ifdef FORWARDING_EN
                end else if (w_ex_is_load && (w_raw_ex_a || w_raw_ex_b)) begin
                    w_next   = hazard_pkg::LOAD_STALL;
                    w_pc_en  = 1'b0;
                    w_bubble = 1'b1;
                end
`else
                end else if (w_raw_ex_a || w_raw_ex_b || w_raw_wb_a || w_raw_wb_b) begin
                    w_pc_en  = 1'b0;
                    w_bubble = 1'b1;
                end
`endif
            end
            hazard_pkg::LOAD_STALL: begin
                w_next = hazard_pkg::RUN;
            end
            hazard_pkg::MEM_WAIT: begin
                if (dm_READY) begin
                    w_next = hazard_pkg::RUN;
                end else begin
                    w_pc_en   = 1'b0;
                    w_ifid_en = 1'b0;
                end
            end
            hazard_pkg::FLUSH: begin
                w_next   = hazard_pkg::RUN;
                w_bubble = 1'b1;
                w_flush  = 1'b1;
            end
            default: begin
                w_next = hazard_pkg::RUN;
            end
        endcase
        // Reset overrides everything: hold the front end and feed NOPs
        if (RESET) begin
            w_pc_en   = 1'b0;
            w_ifid_en = 1'b0;
            w_bubble  = 1'b1;
            w_flush   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != {STALL_CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign PC_ENABLE   = w_pc_en;
    assign IFID_ENABLE = w_ifid_en;
    assign BUBBLE      = w_bubble;
    assign FLUSH       = w_flush;
    assign STALL_CNT   = r_stall_cnt;

`ifdef FORWARDING_EN
    logic w_unused_raw_wb;
    assign w_unused_raw_wb = w_raw_wb_a | w_raw_wb_b;
    assign FWD_A = RESET ? FWD_BANK : w_fwd_a;
    assign FWD_B = RESET ? FWD_BANK : w_fwd_b;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_fwd_a, w_fwd_b};
    assign FWD_A = FWD_BANK;
    assign FWD_B = FWD_BANK;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl (both FORWARDING_EN
//            builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] id_RA, id_RB, ex_WC, wb_WC;
    logic       id_USE_RA, id_USE_RB, ex_W_RB, ex_W_DM, ex_BR_TAKEN, dm_READY, wb_W_RB;
    logic [1:0] ex_S_MXRB;
    logic       PC_ENABLE, IFID_ENABLE, BUBBLE, FLUSH;
    logic [1:0] FWD_A, FWD_B;
    logic [7:0] STALL_CNT;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.REG_AW(4), .STALL_CW(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .id_RA(id_RA), .id_RB(id_RB), .id_USE_RA(id_USE_RA), .id_USE_RB(id_USE_RB),
        .ex_WC(ex_WC), .ex_W_RB(ex_W_RB), .ex_S_MXRB(ex_S_MXRB), .ex_W_DM(ex_W_DM),
        .ex_BR_TAKEN(ex_BR_TAKEN), .dm_READY(dm_READY),
        .wb_WC(wb_WC), .wb_W_RB(wb_W_RB),
        .PC_ENABLE(PC_ENABLE), .IFID_ENABLE(IFID_ENABLE), .BUBBLE(BUBBLE), .FLUSH(FLUSH),
        .FWD_A(FWD_A), .FWD_B(FWD_B), .STALL_CNT(STALL_CNT)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // PC_ENABLE, IFID_ENABLE, BUBBLE, FLUSH packed as one nibble
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check(tag, {4'h0, PC_ENABLE, IFID_ENABLE, BUBBLE, FLUSH}, {4'h0, exp});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        id_RA = 4'd0; id_RB = 4'd0; id_USE_RA = 1'b0; id_USE_RB = 1'b0;
        ex_WC = 4'd0; ex_W_RB = 1'b0; ex_S_MXRB = 2'b00; ex_W_DM = 1'b0;
        ex_BR_TAKEN = 1'b0; dm_READY = 1'b1; wb_WC = 4'd0; wb_W_RB = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        idle();
        @(negedge CLK);
        tick(); tick();
        // ---- reset state
        check_ctl("reset_ctl", 4'b0010);
        check("reset_fwd", {4'h0, FWD_A, FWD_B}, 8'h00);
        check("reset_cnt", STALL_CNT, 8'd0);

        RESET = 1'b0;
        #1;
        check_ctl("run_idle", 4'b1100);
        tick();

        // ---- load-use on r3 through RA
        ex_W_RB = 1'b1; ex_S_MXRB = 2'b01; ex_WC = 4'd3;
        id_RA = 4'd3; id_USE_RA = 1'b1;
        #1;
        check_ctl("lu_stall", 4'b0110);
        check("lu_fwd_a", {6'h0, FWD_A}, 8'h00);
        tick();
        ex_W_RB = 1'b0; ex_S_MXRB = 2'b00; ex_WC = 4'd0;
        wb_WC = 4'd3; wb_W_RB = 1'b1;
        #1;
        check("lu_cnt", STALL_CNT, 8'd1);
`ifdef FORWARDING_EN
        check_ctl("lu_next", 4'b1100);
        check("lu_fwd_wb", {6'h0, FWD_A}, 8'h02);
`else
        check_ctl("lu_next_nofwd", 4'b0110);
        check("lu_fwd_nofwd", {6'h0, FWD_A}, 8'h00);
`endif
        tick();
        idle();
        #1;
        check_ctl("lu_clear", 4'b1100);

        // ---- ALU RAW on r5 through RB, writer in both EX and WB
        ex_W_RB = 1'b1; ex_WC = 4'd5; wb_W_RB = 1'b1; wb_WC = 4'd5;
        id_RB = 4'd5; id_USE_RB = 1'b1;
        #1;
`ifdef FORWARDING_EN
        check("alu_fwd_ex", {6'h0, FWD_B}, 8'h01);
        check_ctl("alu_no_stall", 4'b1100);
        ex_W_RB = 1'b0;
        #1;
        check("alu_fwd_wb", {6'h0, FWD_B}, 8'h02);
        id_USE_RB = 1'b0;
        #1;
        check("alu_fwd_bank", {6'h0, FWD_B}, 8'h00);
        id_USE_RA = 1'b1; id_RA = 4'd5; ex_W_RB = 1'b1;
        #1;
        check("alu_fwd_a_ex", {6'h0, FWD_A}, 8'h01);
`else
        check("alu_fwd_tied", {4'h0, FWD_A, FWD_B}, 8'h00);
        check_ctl("raw_stall0", 4'b0110);
        tick();
        check_ctl("raw_stall1", 4'b0110);
        ex_W_RB = 1'b0;
        tick();
        check_ctl("raw_stall_wb", 4'b0110);
        wb_W_RB = 1'b0;
        #1;
        check_ctl("raw_released", 4'b1100);
`endif
        idle();

        // ---- store with three wait cycles, counter from zero
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        ex_W_DM = 1'b1; dm_READY = 1'b0;
        #1;
        check_ctl("mw_c1", 4'b0000);
        tick();
        ex_BR_TAKEN = 1'b1;
        #1;
        check_ctl("mw_c2_br_ignored", 4'b0000);
        tick();
        ex_BR_TAKEN = 1'b0;
        #1;
        check_ctl("mw_c3", 4'b0000);
        tick();
        dm_READY = 1'b1;
        #1;
        check_ctl("mw_release", 4'b1100);
        tick();
        ex_W_DM = 1'b0;
        #1;
        check("mw_cnt", STALL_CNT, 8'd3);

        // ---- taken branch beats a simultaneous load-use
        ex_W_RB = 1'b1; ex_S_MXRB = 2'b01; ex_WC = 4'd3;
        id_RA = 4'd3; id_USE_RA = 1'b1; ex_BR_TAKEN = 1'b1;
        #1;
        check_ctl("br_flush", 4'b1111);
        tick();
        idle();
        #1;
        check_ctl("br_flush_state", 4'b1111);
        tick();
        check_ctl("br_back_run", 4'b1100);
        check("br_cnt", STALL_CNT, 8'd3);

        // ---- reset during the second MEM_WAIT cycle
        ex_W_DM = 1'b1; dm_READY = 1'b0;
        tick();
        check("rst_mw_cnt", STALL_CNT, 8'd4);
        RESET = 1'b1;
        #1;
        check_ctl("rst_mw_ctl", 4'b0010);
        tick();
        RESET = 1'b0;
        ex_W_DM = 1'b0;
        #1;
        check_ctl("rst_mw_run", 4'b1100);
        check("rst_mw_cnt0", STALL_CNT, 8'd0);

        // ---- saturation
        ex_W_DM = 1'b1; dm_READY = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        check("sat_cnt", STALL_CNT, 8'd255);
        check_ctl("sat_ctl", 4'b0000);
        dm_READY = 1'b1;
        tick();
        idle();
        #1;
        check("sat_hold", STALL_CNT, 8'd255);
        check_ctl("sat_run", 4'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
